// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//
// Shared types for the instruction/data memory arbiter.
//   arb_state_t : which client, if any, owns the single outstanding transaction
//   arb_owner_t : identity of the arbitration winner
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between the instruction-fetch client (i_*) and
// the data load/store client (d_*). Data wins by default; after
// MAX_DATA_STREAK consecutive data grants taken while fetch was waiting, fetch
// is forced through. One transaction is outstanding at a time, and a new grant
// can be issued in the same cycle the previous response returns.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   i_req, i_addr               fetch request (read-only)
//   i_gnt, i_rvalid             fetch accepted / fetch response valid
//   d_req, d_addr, d_we,        data request, address, store enable,
//   d_wdata                     store data
//   d_gnt, d_rvalid             data accepted / data response valid
//   rdata                       response data shared by both clients
//   m_req, m_addr, m_we,        request to memory (combinational mux of
//   m_wdata                     the arbitration winner)
//   m_gnt, m_rvalid, m_rdata    memory accept / response valid / read data
//   busy                        a transaction is outstanding
//
// While rst_n is low every output is forced to zero.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,

    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,

    output logic [DATA_WIDTH-1:0] rdata,

    output logic                  m_req,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_we,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_gnt,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata,

    output logic                  busy
);

    localparam int                  STREAK_W   = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_state_t           state;
    arb_state_t           state_next;
    logic [STREAK_W-1:0]  streak;
    logic [STREAK_W-1:0]  streak_next;

    logic                 free;
    logic                 win_valid;
    arb_owner_t           win_owner;
    logic                 accept;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ARB_IDLE;
            streak <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration: only while no transaction is pending, or the pending one
    // completes this cycle. Fetch wins when alone or when data has used up its
    // streak allowance.
    // -------------------------------------------------------------------------
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        free      = (state == ARB_IDLE) || m_rvalid;
        win_valid = free && (i_req || d_req);
        win_owner = OWNER_D;
        if (i_req && (!d_req || (streak == STREAK_MAX))) begin
            win_owner = OWNER_I;
        end
        accept    = rst_n && win_valid && m_gnt;
    end

    // -------------------------------------------------------------------------
    // Next-state and streak logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        streak_next = streak;
        if (accept) begin
            if (win_owner == OWNER_I) begin
                state_next  = ARB_BUSY_I;
                streak_next = '0;
            end else begin
                state_next = ARB_BUSY_D;
                // The streak only grows while fetch is actually waiting.
                if (!i_req) begin
                    streak_next = '0;
                end else if (streak != STREAK_MAX) begin
                    streak_next = streak + STREAK_W'(1);
                end
            end
        end else if (m_rvalid) begin
            // Response with no follow-on accept: back to idle. In idle this
            // is a no-op, which is how stray responses get dropped.
            state_next = ARB_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. All gated by rst_n so nothing leaks while reset is held.
    // -------------------------------------------------------------------------
    always_comb begin
        m_req    = rst_n && win_valid;
        m_addr   = '0;
        m_we     = 1'b0;
        m_wdata  = '0;
        if (m_req) begin
            if (win_owner == OWNER_I) begin
                m_addr = i_addr;
            end else begin
                m_addr  = d_addr;
                m_we    = d_we;
                m_wdata = d_wdata;
            end
        end

        i_gnt    = accept && (win_owner == OWNER_I);
        d_gnt    = accept && (win_owner == OWNER_D);

        i_rvalid = rst_n && (state == ARB_BUSY_I) && m_rvalid;
        d_rvalid = rst_n && (state == ARB_BUSY_D) && m_rvalid;
        rdata    = rst_n ? m_rdata : '0;
        busy     = rst_n && (state != ARB_IDLE);
    end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed stimulus with a scoreboard: each stimulus step pushes the grant and
// response it expects; a monitor running on the falling edge pops and compares
// whenever the DUT shows a grant or a response. A small memory model answers
// accepted requests one cycle later; unwritten locations read as
// 0xA5A5_0000 | addr.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          d_we;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] rdata;
    logic          m_req;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    logic          m_gnt;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          busy;

    mem_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_DATA_STREAK (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_we     (d_we),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .rdata    (rdata),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_we     (m_we),
        .m_wdata  (m_wdata),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef struct {
        arb_owner_t    owner;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } gnt_t;

    typedef struct {
        arb_owner_t    owner;
        logic [DW-1:0] data;
        logic          chk_data;
    } rsp_t;

    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_gnt(input arb_owner_t o, input logic [AW-1:0] a,
                            input logic we, input logic [DW-1:0] wd);
        gnt_t g;
        g.owner = o;
        g.addr  = a;
        g.we    = we;
        g.wdata = wd;
        exp_gnt.push_back(g);
    endtask

    task automatic push_rsp(input arb_owner_t o, input logic [DW-1:0] d, input logic chk);
        rsp_t r;
        r.owner    = o;
        r.data     = d;
        r.chk_data = chk;
        exp_rsp.push_back(r);
    endtask

    // Monitor: compares every grant and response the DUT presents.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (i_gnt || d_gnt) begin
                    if (exp_gnt.size() == 0) begin
                        check("gnt_unexpected", {30'b0, i_gnt, d_gnt}, 32'h0);
                    end else begin
                        gnt_t g;
                        g = exp_gnt.pop_front();
                        check("gnt_owner", {30'b0, i_gnt, d_gnt},
                              (g.owner == OWNER_I) ? 32'h2 : 32'h1);
                        check("gnt_addr",  m_addr, g.addr);
                        check("gnt_we",    {31'b0, m_we}, {31'b0, g.we});
                        check("gnt_wdata", m_wdata, g.wdata);
                    end
                end
                if (i_rvalid || d_rvalid) begin
                    if (exp_rsp.size() == 0) begin
                        check("rsp_unexpected", {30'b0, i_rvalid, d_rvalid}, 32'h0);
                    end else begin
                        rsp_t r;
                        r = exp_rsp.pop_front();
                        check("rsp_owner", {30'b0, i_rvalid, d_rvalid},
                              (r.owner == OWNER_I) ? 32'h2 : 32'h1);
                        if (r.chk_data) begin
                            check("rsp_data", rdata, r.data);
                        end
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Memory model: 1-cycle latency. Accepts are sampled mid-cycle and the
    // response is presented in the following cycle. stall_rsp swallows a
    // response; inj_valid/inj_data force a stray response onto the bus.
    // -------------------------------------------------------------------------
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          stall_rsp;
    logic          inj_valid;
    logic [DW-1:0] inj_data;

    assign m_rvalid = rsp_valid | inj_valid;
    assign m_rdata  = inj_valid ? inj_data : rsp_data;

    initial begin
        logic          acc;
        logic [DW-1:0] d;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(negedge clk);
            acc = 1'b0;
            d   = '0;
            if (rst_n && m_req && m_gnt && !stall_rsp) begin
                acc = 1'b1;
                if (m_we) begin
                    mem[m_addr] = m_wdata;
                end else if (mem.exists(m_addr)) begin
                    d = mem[m_addr];
                end else begin
                    d = 32'hA5A5_0000 | m_addr;
                end
            end
            @(posedge clk);
            #1;
            rsp_valid = acc;
            rsp_data  = d;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"},   {25'b0, i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, busy}, 32'h0);
        check({tag, "_maddr"}, m_addr,  32'h0);
        check({tag, "_mwdat"}, m_wdata, 32'h0);
        check({tag, "_rdata"}, rdata,   32'h0);
    endtask

    // Starvation-guard pattern, 1 = fetch grant.
    localparam bit [9:0] STREAK_PAT = 10'b10000_10000;

    initial begin
        rst_n     = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_addr    = '0;
        d_we      = 1'b0;
        d_wdata   = '0;
        m_gnt     = 1'b1;
        stall_rsp = 1'b0;
        inj_valid = 1'b0;
        inj_data  = '0;

        // ---- Reset: outputs forced low even with live requests ----
        cyc();
        i_req  = 1'b1;
        i_addr = 32'h44;
        d_req  = 1'b1;
        d_addr = 32'h88;
        d_we   = 1'b1;
        d_wdata = 32'h5555_AAAA;
        mid();
        check_all_zero("reset");
        cyc();
        rst_n   = 1'b1;
        i_req   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_wdata = '0;
        mid();
        check("post_reset_busy",   {31'b0, busy}, 32'h0);
        check("post_reset_streak", 32'(dut.streak), 32'h0);

        // ---- Fetch only, back-to-back ----
        for (int k = 0; k < 3; k++) begin
            cyc();
            i_req  = 1'b1;
            i_addr = 32'(k * 4);
            push_gnt(OWNER_I, 32'(k * 4), 1'b0, '0);
            push_rsp(OWNER_I, 32'hA5A5_0000 | 32'(k * 4), 1'b1);
            mid();
            check("fetch_i_gnt", {31'b0, i_gnt}, 32'h1);
            check("fetch_d_gnt", {31'b0, d_gnt}, 32'h0);
        end
        cyc();
        i_req = 1'b0;
        mid();
        check("fetch_last_rvalid", {31'b0, i_rvalid}, 32'h1);

        // ---- Simultaneous requests: data first ----
        cyc();
        i_req  = 1'b1;
        i_addr = 32'h40;
        d_req  = 1'b1;
        d_addr = 32'h100;
        push_gnt(OWNER_D, 32'h100, 1'b0, '0);
        push_rsp(OWNER_D, 32'hA5A5_0100, 1'b1);
        mid();
        check("simul_first", {30'b0, i_gnt, d_gnt}, 32'h1);
        cyc();
        d_req = 1'b0;
        push_gnt(OWNER_I, 32'h40, 1'b0, '0);
        push_rsp(OWNER_I, 32'hA5A5_0040, 1'b1);
        mid();
        check("simul_second", {30'b0, i_gnt, d_gnt}, 32'h2);
        cyc();
        i_req = 1'b0;
        mid();

        // ---- Starvation guard ----
        cyc();
        i_req  = 1'b1;
        i_addr = 32'h80;
        d_req  = 1'b1;
        d_addr = 32'h300;
        for (int k = 0; k < 10; k++) begin
            if (STREAK_PAT[k]) begin
                push_gnt(OWNER_I, 32'h80, 1'b0, '0);
                push_rsp(OWNER_I, 32'hA5A5_0080, 1'b1);
            end else begin
                push_gnt(OWNER_D, 32'h300, 1'b0, '0);
                push_rsp(OWNER_D, 32'hA5A5_0300, 1'b1);
            end
            mid();
            check("streak_pattern", {30'b0, i_gnt, d_gnt}, STREAK_PAT[k] ? 32'h2 : 32'h1);
            if (k > 0 && STREAK_PAT[k-1]) begin
                check("streak_cleared", 32'(dut.streak), 32'h0);
            end
            cyc();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        mid();
        check("streak_cleared_end", 32'(dut.streak), 32'h0);

        // ---- Store then load ----
        cyc();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h200;
        d_wdata = 32'hDEAD_BEEF;
        push_gnt(OWNER_D, 32'h200, 1'b1, 32'hDEAD_BEEF);
        push_rsp(OWNER_D, '0, 1'b0);
        mid();
        check("store_m_we",  {31'b0, m_we},  32'h1);
        check("store_d_gnt", {31'b0, d_gnt}, 32'h1);
        cyc();
        d_we    = 1'b0;
        d_wdata = '0;
        push_gnt(OWNER_D, 32'h200, 1'b0, '0);
        push_rsp(OWNER_D, 32'hDEAD_BEEF, 1'b1);
        mid();
        check("load_m_we",        {31'b0, m_we},     32'h0);
        check("store_ack_rvalid", {31'b0, d_rvalid}, 32'h1);
        cyc();
        d_req = 1'b0;
        mid();
        check("load_rdata", rdata, 32'hDEAD_BEEF);

        // ---- Memory backpressure ----
        cyc();
        m_gnt  = 1'b0;
        d_req  = 1'b1;
        d_addr = 32'h400;
        push_gnt(OWNER_D, 32'h400, 1'b0, '0);
        push_rsp(OWNER_D, 32'hA5A5_0400, 1'b1);
        for (int k = 0; k < 3; k++) begin
            mid();
            check("bp_no_gnt", {31'b0, d_gnt}, 32'h0);
            check("bp_m_req",  {31'b0, m_req}, 32'h1);
            check("bp_m_addr", m_addr, 32'h400);
            cyc();
        end
        m_gnt = 1'b1;
        mid();
        check("bp_release_gnt", {31'b0, d_gnt}, 32'h1);
        cyc();
        d_req = 1'b0;
        mid();

        // ---- Reset mid-transaction; late response is dropped ----
        cyc();
        stall_rsp = 1'b1;
        d_req     = 1'b1;
        d_addr    = 32'h500;
        push_gnt(OWNER_D, 32'h500, 1'b0, '0);
        mid();
        check("rst_txn_gnt", {31'b0, d_gnt}, 32'h1);
        cyc();
        d_req     = 1'b0;
        stall_rsp = 1'b0;
        mid();
        check("rst_txn_busy", {31'b0, busy}, 32'h1);
        cyc();
        rst_n     = 1'b0;
        i_req     = 1'b1;
        i_addr    = 32'h600;
        d_req     = 1'b1;
        d_addr    = 32'h700;
        inj_valid = 1'b1;
        inj_data  = 32'h1234_5678;
        mid();
        check_all_zero("rst_mid_a");
        cyc();
        mid();
        check_all_zero("rst_mid_b");
        cyc();
        rst_n = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        mid();
        check("late_d_rvalid", {31'b0, d_rvalid}, 32'h0);
        check("late_i_rvalid", {31'b0, i_rvalid}, 32'h0);
        check("late_busy",     {31'b0, busy},     32'h0);
        cyc();
        inj_valid = 1'b0;
        mid();

        // ---- Drain ----
        repeat (3) cyc();
        check("gnt_queue_empty", 32'(exp_gnt.size()), 32'h0);
        check("rsp_queue_empty", 32'(exp_rsp.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_arbiter
